// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and the IF/ID boundary.
package fetch_pkg;

  // Fetch FSM: FETCH owns the bus, HOLD presents one buffered instruction.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] PC_RESET    = 32'h8000_0000;

  localparam int unsigned IFID_AW = 32;
  localparam int unsigned IFID_DW = 32;

  // Payload carried across the IF/ID valid/ready boundary.
  typedef struct packed {
    logic [IFID_AW-1:0] pc;
    logic [IFID_DW-1:0] instr;
  } ifid_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: Wishbone B4 classic read master, PC tracking, redirect
// handling with stale-fetch discard, and a single-entry IF/ID output buffer.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(PC_RESET)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  output logic                    if_valid,
  input  logic                    if_ready,
  output logic [ADDR_WIDTH-1:0]   if_pc,
  output logic [DATA_WIDTH-1:0]   if_instr
);

  fetch_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   pending_q, pending_d;
  logic                    discard_q, discard_d;
  logic                    cyc_q, cyc_d;
  logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic                    vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]   ifpc_q, ifpc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;

  logic [ADDR_WIDTH-1:0]   redir_pc;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [ADDR_WIDTH-1:0]   restart_pc;
  logic                    unused_redir_lsb;

  // Redirect targets are word aligned; the low bits are simply dropped.
  assign redir_pc         = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign pc_inc           = pc_q + ADDR_WIDTH'(INSTR_BYTES);
  // A redirect landing on the ack edge overrides any earlier pending target.
  assign restart_pc       = redirect_valid ? redir_pc : pending_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state: a clean ack moves to HOLD; consumption or redirect returns to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (cyc_q && wb_ack_i && !discard_q && !redirect_valid) state_d = HOLD;
      HOLD:  if (redirect_valid || (vld_q && if_ready))               state_d = FETCH;
    endcase
  end

  // Next values of every registered output and of the PC bookkeeping.
  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    discard_d = discard_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    vld_d     = vld_q;
    ifpc_d    = ifpc_q;
    instr_d   = instr_q;
    case (state_q)
      FETCH: begin
        if (!cyc_q) begin
          // Idle slot (after reset or a discarded fetch): issue at the current PC,
          // or straight at a redirect target arriving now. Stray acks are ignored.
          cyc_d = 1'b1;
          if (redirect_valid) begin
            pc_d  = redir_pc;
            adr_d = redir_pc;
          end else begin
            adr_d = pc_q;
          end
        end else if (wb_ack_i) begin
          cyc_d = 1'b0;
          if (discard_q || redirect_valid) begin
            // Stale data: drop it and restart from the latest redirect target.
            pc_d      = restart_pc;
            adr_d     = restart_pc;
            discard_d = 1'b0;
          end else begin
            vld_d   = 1'b1;
            ifpc_d  = pc_q;
            instr_d = wb_dat_i;
          end
        end else if (redirect_valid) begin
          // Cannot retract a classic-cycle request; mark it stale and remember
          // the newest target. Address stays put until ack.
          discard_d = 1'b1;
          pending_d = redir_pc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          vld_d = 1'b0;
          pc_d  = redir_pc;
          adr_d = redir_pc;
          cyc_d = 1'b1;
        end else if (vld_q && if_ready) begin
          vld_d = 1'b0;
          pc_d  = pc_inc;
          adr_d = pc_inc;
          cyc_d = 1'b1;
        end
      end
    endcase
    sel_d = cyc_d ? '1 : '0;
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= PC_ADDR;
      pending_q <= PC_ADDR;
      discard_q <= 1'b0;
      cyc_q     <= 1'b0;
      sel_q     <= '0;
      adr_q     <= PC_ADDR;
      vld_q     <= 1'b0;
      ifpc_q    <= PC_ADDR;
      instr_q   <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      cyc_q     <= cyc_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      vld_q     <= vld_d;
      ifpc_q    <= ifpc_d;
      instr_q   <= instr_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign if_valid = vld_q;
  assign if_pc    = ifpc_q;
  assign if_instr = instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: Wishbone slave model with variable wait states,
// directed scenarios, then randomized ready/redirect/reset traffic. The
// reference model is "the next instruction the pipeline must receive".
module tb_if_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  if_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PC_ADDR(PC0)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  ifid_t       exp_q[$];
  logic        prev_cyc = 1'b0;
  logic        new_req  = 1'b0;
  logic [31:0] req_adr  = '0;
  int          ws_left  = 0;
  int          ws_next  = 2;
  bit          rand_ws  = 1'b0;
  bit          slave_en = 1'b1;

  // Instruction memory contents seen by the slave model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == PC0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the next instruction delivered must be the one at pc.
  task automatic expect_next(input logic [31:0] pc);
    ifid_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.delete();
    exp_q.push_back(e);
  endtask

  // Advance one cycle, check bus signalling, and play the Wishbone slave.
  task automatic step();
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    new_req = wb_cyc_o && !prev_cyc;
    if (wb_cyc_o) begin
      chk("stb_busy", wb_stb_o, 1);
      chk("we", wb_we_o, 0);
      chk("sel_busy", wb_sel_o, 4'hF);
    end else begin
      chk("stb_idle", wb_stb_o, 0);
      chk("sel_idle", wb_sel_o, 4'h0);
    end
    if (new_req) begin
      req_adr = wb_adr_o;
      chk("req_adr", wb_adr_o, (exp_q.size() > 0) ? exp_q[0].pc : 32'hxxxx_xxxx);
      ws_left = ws_next;
      ws_next = rand_ws ? int'($urandom_range(0, 4)) : 4;
    end else if (wb_cyc_o) begin
      chk("adr_stable", wb_adr_o, req_adr);
    end
    if (slave_en) begin
      if (wb_ack_i) wb_ack_i = 1'b0;
      else if (wb_cyc_o) begin
        if (ws_left == 0) begin
          wb_ack_i = 1'b1;
          wb_dat_i = mem_word(wb_adr_o);
        end else ws_left--;
      end
    end
    prev_cyc = wb_cyc_o;
  endtask

  task automatic wait_req(input string name, input int bound, input bit novalid);
    for (int i = 0; i < bound; i++) begin
      step();
      if (novalid) chk({name, "_novalid"}, if_valid, 0);
      if (new_req) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s: timeout waiting for bus request", name);
  endtask

  task automatic wait_valid(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (if_valid) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s: timeout waiting for if_valid", name);
  endtask

  task automatic wait_ack(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (wb_ack_i) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s: timeout waiting for ack", name);
  endtask

  // Monitor: every accepted instruction is compared against the model.
  always @(negedge clk) begin
    ifid_t e;
    ifid_t nx;
    if (reset === 1'b1 && if_valid === 1'b1 && if_ready === 1'b1 && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL accept: unexpected instruction pc %h", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("accept_pc", if_pc, e.pc);
        chk("accept_instr", if_instr, e.instr);
        nx.pc    = e.pc + 32'd4;
        nx.instr = mem_word(nx.pc);
        exp_q.push_back(nx);
        n_acc++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rec_pc, rec_instr, tgt;
    int r;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    wb_ack_i = 1'b0; wb_dat_i = '0; if_ready = 1'b1;
    expect_next(PC0);
    repeat (3) step();
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_adr", wb_adr_o, PC0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, PC0);
    chk("rst_instr", if_instr, NOP_INSTR);

    // First fetch, two wait states, one-cycle ack-to-valid latency.
    reset = 1'b1;
    step();
    chk("t1_first_cyc", wb_cyc_o, 1);
    chk("t1_first_adr", wb_adr_o, PC0);
    step(); step();
    chk("t1_ack_now", wb_ack_i, 1);
    chk("t1_not_yet_valid", if_valid, 0);
    step();
    chk("t1_valid", if_valid, 1);
    chk("t1_pc", if_pc, PC0);
    chk("t1_instr", if_instr, 32'h0010_0093);
    chk("t1_cyc_low", wb_cyc_o, 0);
    step();
    chk("t1_next_req", new_req, 1);
    chk("t1_next_adr", wb_adr_o, 32'h8000_0004);

    // Back-pressure: output held, bus idle.
    if_ready = 1'b0;
    wait_valid("t2", 20);
    rec_pc = if_pc; rec_instr = if_instr;
    chk("t2_pc", rec_pc, 32'h8000_0004);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", if_valid, 1);
      chk("t2_hold_cyc", wb_cyc_o, 0);
      chk("t2_hold_pc", if_pc, rec_pc);
      chk("t2_hold_instr", if_instr, rec_instr);
    end
    if_ready = 1'b1;
    step();
    chk("t2_next_req", new_req, 1);
    chk("t2_next_adr", wb_adr_o, 32'h8000_0008);

    // Redirect one cycle into an outstanding fetch.
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; expect_next(32'h8000_0100);
    wait_req("t3", 20, 1'b1);
    chk("t3_adr", wb_adr_o, 32'h8000_0100);

    // Redirect coinciding with ack.
    wait_ack("t4a", 20);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0400; expect_next(32'h8000_0400);
    wait_req("t4a", 20, 1'b1);
    chk("t4a_adr", wb_adr_o, 32'h8000_0400);

    // Redirect in HOLD while if_ready is high.
    wait_valid("t4b", 20);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0500; expect_next(32'h8000_0500);
    wait_req("t4b", 20, 1'b1);
    chk("t4b_adr", wb_adr_o, 32'h8000_0500);

    // Two redirects before ack: last one wins.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; expect_next(32'h8000_0200);
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; expect_next(32'h8000_0300);
    wait_req("t5", 20, 1'b1);
    chk("t5_adr", wb_adr_o, 32'h8000_0300);

    // Reset mid-fetch, stale ack right after release.
    slave_en = 1'b0;
    step();
    reset = 1'b0; expect_next(PC0);
    step();
    chk("t6_cyc", wb_cyc_o, 0);
    chk("t6_stb", wb_stb_o, 0);
    chk("t6_valid", if_valid, 0);
    chk("t6_instr", if_instr, NOP_INSTR);
    chk("t6_pc", if_pc, PC0);
    chk("t6_adr", wb_adr_o, PC0);
    reset = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    step();
    chk("t6_restart_cyc", wb_cyc_o, 1);
    chk("t6_restart_adr", wb_adr_o, PC0);
    wb_ack_i = 1'b0; slave_en = 1'b1;
    step();
    chk("t6_stale_ignored", if_valid, 0);
    wait_valid("t6", 20);
    chk("t6_pc_after", if_pc, PC0);
    chk("t6_instr_after", if_instr, 32'h0010_0093);

    // PC wrap from the top of the address space (low target bits ignored).
    wait_req("t7a", 40, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFD; expect_next(32'hFFFF_FFFC);
    wait_req("t7b", 20, 1'b1);
    chk("t7_top_adr", wb_adr_o, 32'hFFFF_FFFC);
    wait_req("t7c", 40, 1'b0);
    chk("t7_wrap_adr", wb_adr_o, 32'h0000_0000);

    // Randomized traffic.
    rand_ws = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if_ready = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        redirect_valid = 1'b1; redirect_pc = tgt; expect_next(tgt & ~32'h3);
      end else if (r == 4) begin
        reset = 1'b0; expect_next(PC0);
      end
      step();
      reset = 1'b1;
    end
    if_ready = 1'b1;
    repeat (40) step();
    chk("progress", (n_acc > 50) ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage and the producer side of the IF/ID boundary. It holds the PC, fetches one 32-bit instruction per transaction as a Wishbone B4 classic master, and presents {pc, instruction} to the IF/ID register through a valid/ready handshake. It accepts PC redirects from the branch/jump resolution logic. It discards any in-flight fetch made stale by a redirect.

Parameters:
PC_ADDR, 32'h8000_0000, PC value loaded at reset
ADDR_WIDTH, 32, PC and bus address width
DATA_WIDTH, 32, instruction and bus data width

Ports:
clk  in  1  clock; everything is on the rising edge
reset  in  1  synchronous, active-low reset: reset==0 at a rising edge resets the block
redirect_valid  in  1  one-cycle pulse; the fetch stream must restart at redirect_pc
redirect_pc  in  ADDR_WIDTH  target address; bits [1:0] are ignored and treated as 0
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  always 0
wb_sel_o  out  DATA_WIDTH/8  always all ones while stb=1, otherwise 0
wb_adr_o  out  ADDR_WIDTH  fetch address (current PC)
wb_dat_i  in  DATA_WIDTH  read data
wb_ack_i  in  1  transfer acknowledge
if_valid  out  1  if_pc and if_instr are valid
if_ready  in  1  the IF/ID register accepts the instruction this cycle
if_pc  out  ADDR_WIDTH  address of the presented instruction
if_instr  out  DATA_WIDTH  presented instruction word

Behaviour:
- Reset (reset==0 at an edge) sets:
  - pc=PC_ADDR, state=FETCH
  - wb_cyc_o=wb_stb_o=0, wb_sel_o=0, wb_adr_o=PC_ADDR
  - if_valid=0, if_pc=PC_ADDR, if_instr=32'h0000_0013 (NOP)
  - discard=0
- Reset mid-transaction drops cyc/stb in the next cycle, aborting the cycle as Wishbone allows. A late ack after that is ignored.
- All outputs are registered.
- States:
  - FETCH: cyc=stb=1, adr=pc. adr, sel and we stay stable until ack.
  - HOLD: cyc=stb=0, if_valid=1.
- First request: cyc/stb go high in the first cycle after reset is released.
- FETCH, ack with discard=0 and no redirect this cycle:
  - In the next cycle, if_instr=wb_dat_i, if_pc=pc, if_valid=1, cyc=stb=0.
  - state goes to HOLD.
  - Latency is ack edge + 1 cycle to if_valid.
- HOLD with if_valid & if_ready: pc<=pc+4 (wraps modulo 2^ADDR_WIDTH). Next cycle: if_valid=0, FETCH with the new address.
- HOLD with if_ready=0: if_valid, if_pc and if_instr hold unchanged indefinitely.
- Redirect in HOLD:
  - if_valid<=0 and pc<=redirect_pc&~3; the presented instruction is dropped even if if_ready=1 in the same cycle.
  - state goes to FETCH.
- Redirect in FETCH without ack: discard<=1 and pending_pc<=redirect_pc&~3. The outstanding request keeps its old address until ack.
- Multiple redirects before ack: the last one wins.
- Ack while discard=1, or ack coinciding with a redirect:
  - The data is dropped and if_valid stays 0.
  - pc<=pending_pc, or redirect_pc if the redirect arrived this cycle (a same-cycle redirect overrides pending_pc).
  - discard<=0.
  - stb/cyc are low for one cycle, then FETCH issues at the new pc.
- No prefetch: at most one transaction is outstanding and at most one instruction is buffered.
- Ack outside FETCH is ignored.
- Throughput is one instruction per (bus latency + 2) cycles when if_ready is held at 1.

Decomposition:
- Package fetch_pkg holds:
  - the state enum {FETCH, HOLD}
  - INSTR_BYTES=4
  - NOP_INSTR=32'h0000_0013
  - PC_RESET default 32'h8000_0000
  - a struct bundling {pc, instr} for the IF/ID interface, so the IF/ID register and this block share it
- No sub-module. The Wishbone master handshake and PC logic are one FSM, about 150–200 lines.

Test Plan:
- Reset release with ack after 2 wait states and data 32'h0010_0093, if_ready=1 -> adr=32'h8000_0000 held stable; if_valid=1 with if_pc=32'h8000_0000, if_instr=32'h0010_0093 one cycle after ack; next request at 32'h8000_0004.
- Hold if_ready=0 for 5 cycles while if_valid=1 -> no bus activity and outputs unchanged; raise if_ready -> next fetch at pc+4.
- Redirect to 32'h8000_0102 one cycle into an outstanding fetch at 32'h8000_0008 -> adr stays 32'h8000_0008 until ack; data discarded with if_valid never set; next fetch at 32'h8000_0100.
- Redirect in the same cycle as ack, and separately redirect in HOLD with if_ready=1 -> data dropped in both cases; next fetch at the redirect target.
- Two redirects (32'h8000_0200, then 32'h8000_0300) before ack -> next fetch at 32'h8000_0300 only.
- Assert reset mid-FETCH, then ack one cycle after reset is released -> cyc/stb low, stale ack ignored, fetch restarts at 32'h8000_0000, if_instr=NOP.
- Run pc from 32'hFFFF_FFFC -> next fetch at 32'h0000_0000.
